// File: rtl/accel_pkg.sv
// Shared types and constants for the tri-accelerator subsystem:
// accelerator select and top-level FSM state encodings, plus the BRAM bank map.
package accel_pkg;

    typedef enum logic [1:0] {
        ACCEL_MLP = 2'd0,
        ACCEL_CNN = 2'd1,
        ACCEL_RNN = 2'd2
    } accel_type_e;

    typedef enum logic [2:0] {
        STATE_IDLE         = 3'd0,
        STATE_LOAD_WEIGHTS = 3'd1,
        STATE_LOAD_INPUT   = 3'd2,
        STATE_COMPUTE      = 3'd3,
        STATE_STORE_OUTPUT = 3'd4,
        STATE_DONE         = 3'd5
    } state_e;

    localparam int BRAM_BANKS = 19;

    localparam int BANK_INPUT_0      = 0;
    localparam int BANK_INPUT_1      = 1;
    localparam int BANK_WEIGHT_0     = 2;
    localparam int BANK_WEIGHT_11    = 13;
    localparam int BANK_ACTIVATION_0 = 14;
    localparam int BANK_ACTIVATION_1 = 15;
    localparam int BANK_BIAS         = 16;
    localparam int BANK_OUTPUT_0     = 17;
    localparam int BANK_OUTPUT_1     = 18;

endpackage

// File: rtl/pm_bank_policy.sv
// Combinational FSM-state -> BRAM bank power mask decoder.
// I/O banks are always on; weights stay powered from load through done;
// activations only while computing/storing; bias only while computing.
module pm_bank_policy
    import accel_pkg::*;
(
    input  state_e                  current_state,
    output logic [BRAM_BANKS-1:0]   bank_mask
);

    logic [BRAM_BANKS-1:0] io_mask;
    logic [BRAM_BANKS-1:0] wgt_mask;
    logic [BRAM_BANKS-1:0] act_mask;

    // Build the bank-group masks from the bank index map
    always_comb begin
        io_mask  = '0;
        wgt_mask = '0;
        act_mask = '0;
        io_mask[BANK_INPUT_0]  = 1'b1;
        io_mask[BANK_INPUT_1]  = 1'b1;
        io_mask[BANK_OUTPUT_0] = 1'b1;
        io_mask[BANK_OUTPUT_1] = 1'b1;
        for (int i = BANK_WEIGHT_0; i <= BANK_WEIGHT_11; i++) begin
            wgt_mask[i] = 1'b1;
        end
        act_mask[BANK_ACTIVATION_0] = 1'b1;
        act_mask[BANK_ACTIVATION_1] = 1'b1;
    end

    // Select the mask for the current state; unknown encodings fall back to IDLE
    always_comb begin
        bank_mask = io_mask;
        case (current_state)
            STATE_LOAD_WEIGHTS,
            STATE_LOAD_INPUT,
            STATE_DONE:         bank_mask = io_mask | wgt_mask;
            STATE_COMPUTE:      bank_mask = '1;
            STATE_STORE_OUTPUT: bank_mask = io_mask | wgt_mask | act_mask;
            default:            bank_mask = io_mask;
        endcase
    end

endmodule

// File: rtl/power_manager.sv
// Power manager for the MLP/CNN/RNN accelerators: clock-gate enables,
// BRAM bank power enables and DSP operand-isolation enables, all
// combinational from the inputs and forced low until the post-reset
// ready flag is set.
// Optional build macro PM_ACTIVITY_CNT_EN adds saturating per-accelerator
// active-cycle counters.
module power_manager
    import accel_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  accel_type_e           active_accel,
    input  logic                  accel_active,
    input  state_e                current_state,
    output logic                  mlp_clk_en,
    output logic                  cnn_clk_en,
    output logic                  rnn_clk_en,
    output logic [BRAM_BANKS-1:0] bank_power_en,
    output logic                  mlp_dsp_en,
    output logic                  cnn_dsp_en,
    output logic                  rnn_dsp_en
`ifdef PM_ACTIVITY_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]  mlp_active_cycles,
    output logic [CNT_WIDTH-1:0]  cnn_active_cycles,
    output logic [CNT_WIDTH-1:0]  rnn_active_cycles
`endif
);

    if (CNT_WIDTH < 1) begin : g_bad_cnt_width
        $error("power_manager: CNT_WIDTH must be at least 1");
    end

    logic                  pm_ready_q;
    logic                  pm_ready_d;
    logic [2:0]            clk_en;     // {rnn, cnn, mlp}
    logic [2:0]            dsp_en;
    logic                  in_compute;
    logic [BRAM_BANKS-1:0] bank_mask;

    pm_bank_policy u_bank_policy (
        .current_state (current_state),
        .bank_mask     (bank_mask)
    );

    // Ready flag rises on the first edge out of reset and then holds
    always_comb begin
        pm_ready_d = 1'b1;
    end

    // Ready flag register; async clear makes outputs drop with rst_n
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pm_ready_q <= 1'b0;
        else        pm_ready_q <= pm_ready_d;
    end

    // Decode enables; an unknown accel encoding leaves every enable low
    always_comb begin
        clk_en     = '0;
        in_compute = (current_state == STATE_COMPUTE);
        if (pm_ready_q && accel_active) begin
            clk_en[0] = (active_accel == ACCEL_MLP);
            clk_en[1] = (active_accel == ACCEL_CNN);
            clk_en[2] = (active_accel == ACCEL_RNN);
        end
        dsp_en = clk_en & {3{in_compute}};
    end

    assign mlp_clk_en    = clk_en[0];
    assign cnn_clk_en    = clk_en[1];
    assign rnn_clk_en    = clk_en[2];
    assign mlp_dsp_en    = dsp_en[0];
    assign cnn_dsp_en    = dsp_en[1];
    assign rnn_dsp_en    = dsp_en[2];
    assign bank_power_en = pm_ready_q ? bank_mask : '0;

`ifdef PM_ACTIVITY_CNT_EN
    logic [2:0][CNT_WIDTH-1:0] cnt_q;
    logic [2:0][CNT_WIDTH-1:0] cnt_d;

    // Saturating count of cycles each accelerator clock is enabled
    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < 3; i++) begin
            if (clk_en[i] && (cnt_q[i] != '1)) cnt_d[i] = cnt_q[i] + 1'b1;
        end
    end

    // Activity counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign mlp_active_cycles = cnt_q[0];
    assign cnn_active_cycles = cnt_q[1];
    assign rnn_active_cycles = cnt_q[2];
`endif

endmodule

// File: tb/tb_power_manager.sv
// Self-checking bench for power_manager. Expected output vectors are pushed
// to a scoreboard queue as stimulus is applied and popped/compared after the
// next clock edge. Vector packing: {mlp,cnn,rnn clk_en, mlp,cnn,rnn dsp_en, banks}.
module tb_power_manager;
    import accel_pkg::*;

    localparam int CW = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    accel_type_e active_accel = ACCEL_MLP;
    logic        accel_active = 1'b0;
    state_e      current_state = STATE_IDLE;
    logic        mlp_clk_en, cnn_clk_en, rnn_clk_en;
    logic        mlp_dsp_en, cnn_dsp_en, rnn_dsp_en;
    logic [BRAM_BANKS-1:0] bank_power_en;
`ifdef PM_ACTIVITY_CNT_EN
    logic [CW-1:0] mlp_active_cycles, cnn_active_cycles, rnn_active_cycles;
`endif

    power_manager #(.CNT_WIDTH(CW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .active_accel  (active_accel),
        .accel_active  (accel_active),
        .current_state (current_state),
        .mlp_clk_en    (mlp_clk_en),
        .cnn_clk_en    (cnn_clk_en),
        .rnn_clk_en    (rnn_clk_en),
        .bank_power_en (bank_power_en),
        .mlp_dsp_en    (mlp_dsp_en),
        .cnn_dsp_en    (cnn_dsp_en),
        .rnn_dsp_en    (rnn_dsp_en)
`ifdef PM_ACTIVITY_CNT_EN
        ,
        .mlp_active_cycles (mlp_active_cycles),
        .cnn_active_cycles (cnn_active_cycles),
        .rnn_active_cycles (rnn_active_cycles)
`endif
    );

    always #5 clk = ~clk;

    localparam logic [18:0] B_IDLE  = 19'h60003;
    localparam logic [18:0] B_WGT   = 19'h63FFF;
    localparam logic [18:0] B_ALL   = 19'h7FFFF;
    localparam logic [18:0] B_STORE = 19'h6FFFF;

    typedef struct {
        string       name;
        logic [24:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic logic [24:0] obs_vec();
        return {mlp_clk_en, cnn_clk_en, rnn_clk_en,
                mlp_dsp_en, cnn_dsp_en, rnn_dsp_en, bank_power_en};
    endfunction

    // Drive inputs and record what the outputs should be after the next edge
    task automatic apply(input string nm, input logic [1:0] acc, input logic act,
                         input logic [2:0] st, input logic [2:0] e_clk,
                         input logic [2:0] e_dsp, input logic [18:0] e_bank);
        exp_t e;
        active_accel  = accel_type_e'(acc);
        accel_active  = act;
        current_state = state_e'(st);
        e.name = nm;
        e.exp  = {e_clk, e_dsp, e_bank};
        sb.push_back(e);
    endtask

    task automatic test_reset();
        exp_t e;
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            apply("reset_hold", 2'd0, 1'b1, 3'd3, 3'b000, 3'b000, 19'h0);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_cmp++;
            if (obs_vec() !== e.exp) begin
                n_bad++;
                $display("FAIL %s cyc%0d: got %h want %h", e.name, i, obs_vec(), e.exp);
            end
        end
        rst_n = 1'b1;
        apply("ready_idle", 2'd0, 1'b0, 3'd0, 3'b000, 3'b000, B_IDLE);
        @(posedge clk); #1;
        e = sb.pop_front();
        n_cmp++;
        if (obs_vec() !== e.exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", e.name, obs_vec(), e.exp);
        end
    endtask

    task automatic test_clk_sel();
        exp_t e;
        apply("sel_mlp", 2'd0, 1'b1, 3'd0, 3'b100, 3'b000, B_IDLE);
        apply("sel_cnn", 2'd1, 1'b1, 3'd0, 3'b010, 3'b000, B_IDLE);
        apply("sel_rnn", 2'd2, 1'b1, 3'd0, 3'b001, 3'b000, B_IDLE);
        apply("cnn_inactive", 2'd1, 1'b0, 3'd3, 3'b000, 3'b000, B_ALL);
        // Re-drive from the recorded order: each entry's inputs precede its check
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: begin active_accel = ACCEL_MLP; accel_active = 1'b1; current_state = STATE_IDLE; end
                1: begin active_accel = ACCEL_CNN; accel_active = 1'b1; current_state = STATE_IDLE; end
                2: begin active_accel = ACCEL_RNN; accel_active = 1'b1; current_state = STATE_IDLE; end
                default: begin active_accel = ACCEL_CNN; accel_active = 1'b0; current_state = STATE_COMPUTE; end
            endcase
            @(posedge clk); #1;
            e = sb.pop_front();
            n_cmp++;
            if (obs_vec() !== e.exp) begin
                n_bad++;
                $display("FAIL %s: got %h want %h", e.name, obs_vec(), e.exp);
            end
        end
    endtask

    task automatic test_compute();
        exp_t e;
        apply("mlp_compute", 2'd0, 1'b1, 3'd3, 3'b100, 3'b100, B_ALL);
        @(posedge clk); #1;
        e = sb.pop_front();
        n_cmp++;
        if (obs_vec() !== e.exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", e.name, obs_vec(), e.exp);
        end
        apply("rnn_compute", 2'd2, 1'b1, 3'd3, 3'b001, 3'b001, B_ALL);
        @(posedge clk); #1;
        e = sb.pop_front();
        n_cmp++;
        if (obs_vec() !== e.exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", e.name, obs_vec(), e.exp);
        end
    endtask

    task automatic test_state_walk();
        exp_t e;
        logic [18:0] banks [7] = '{B_IDLE, B_WGT, B_WGT, B_ALL, B_STORE, B_WGT, B_IDLE};
        logic [2:0]  sts   [7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
        for (int i = 0; i < 7; i++) begin
            apply($sformatf("walk_cnn_s%0d", sts[i]), 2'd1, 1'b1, sts[i], 3'b010,
                  (sts[i] == 3'd3) ? 3'b010 : 3'b000, banks[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_cmp++;
            if (obs_vec() !== e.exp) begin
                n_bad++;
                $display("FAIL %s: got %h want %h", e.name, obs_vec(), e.exp);
            end
        end
    endtask

    task automatic test_undefined();
        exp_t e;
        apply("accel_3_compute", 2'd3, 1'b1, 3'd3, 3'b000, 3'b000, B_ALL);
        @(posedge clk); #1;
        e = sb.pop_front();
        n_cmp++;
        if (obs_vec() !== e.exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", e.name, obs_vec(), e.exp);
        end
        apply("state_7", 2'd0, 1'b1, 3'd7, 3'b100, 3'b000, B_IDLE);
        @(posedge clk); #1;
        e = sb.pop_front();
        n_cmp++;
        if (obs_vec() !== e.exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", e.name, obs_vec(), e.exp);
        end
        apply("accel_3_state_6", 2'd3, 1'b1, 3'd6, 3'b000, 3'b000, B_IDLE);
        @(posedge clk); #1;
        e = sb.pop_front();
        n_cmp++;
        if (obs_vec() !== e.exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", e.name, obs_vec(), e.exp);
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        apply("pre_reset_compute", 2'd0, 1'b1, 3'd3, 3'b100, 3'b100, B_ALL);
        @(posedge clk); #1;
        e = sb.pop_front();
        n_cmp++;
        if (obs_vec() !== e.exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", e.name, obs_vec(), e.exp);
        end
        // Drop reset between edges; outputs must clear before any edge arrives
        #1 rst_n = 1'b0;
        e.name = "async_reset";
        e.exp  = '0;
        sb.push_back(e);
        #1;
        e = sb.pop_front();
        n_cmp++;
        if (obs_vec() !== e.exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", e.name, obs_vec(), e.exp);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        apply("post_reset_compute", 2'd0, 1'b1, 3'd3, 3'b100, 3'b100, B_ALL);
        @(posedge clk); #1;
        e = sb.pop_front();
        n_cmp++;
        if (obs_vec() !== e.exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", e.name, obs_vec(), e.exp);
        end
    endtask

`ifdef PM_ACTIVITY_CNT_EN
    task automatic test_activity_cnt();
        logic [CW-1:0] exp_mlp;
        rst_n = 1'b0;
        accel_active = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        exp_mlp = '0;
        active_accel  = ACCEL_MLP;
        accel_active  = 1'b1;
        current_state = STATE_COMPUTE;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            exp_mlp++;
        end
        accel_active = 1'b0;
        n_cmp++;
        if (mlp_active_cycles !== exp_mlp) begin
            n_bad++;
            $display("FAIL mlp_cnt: got %0d want %0d", mlp_active_cycles, exp_mlp);
        end
        n_cmp++;
        if ({cnn_active_cycles, rnn_active_cycles} !== '0) begin
            n_bad++;
            $display("FAIL other_cnt: got %0d/%0d want 0", cnn_active_cycles, rnn_active_cycles);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (mlp_active_cycles !== '0) begin
            n_bad++;
            $display("FAIL mlp_cnt_reset: got %0d want 0", mlp_active_cycles);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        test_reset();
        test_clk_sel();
        test_compute();
        test_state_walk();
        test_undefined();
        test_async_reset();
`ifdef PM_ACTIVITY_CNT_EN
        test_activity_cnt();
`endif
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_leftover: got %0d entries want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
